calc_muldiv_sequencer: RTL

//   Multi-cycle sequencer for the calculator's multiply and divide operations.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_mag_split.sv | 30 +++
 rtl/calc_muldiv_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the calculator multiply/divide
//               sequencer: FSM state encodings, opcode constants and the
//               default data width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

   // Default operand/result width.
   localparam int W_DEFAULT = 11;

   // Opcodes presented on Op together with Start.
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   // Sequencer states; the numeric codes are visible on the State port.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MUL  = 3'd2,
      DIV  = 3'd3,
      SIGN = 3'd4,
      DONE = 3'd5
   } state_e;

endpackage : calc_pkg

`default_nettype wire

// File: rtl/calc_mag_split.sv
// ============================================================================
// Module      : calc_mag_split
// Description : Splits a signed two's-complement value into its sign bit and
//               an unsigned magnitude of the same width. The most negative
//               value maps to magnitude 2^(W-1), which still fits unsigned.
// Ports       : value - signed input value (W bits)
//               sign  - sign bit of value
//               mag   - unsigned magnitude |value| (W bits)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_mag_split
   import calc_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [W-1:0] value,
   output logic         sign,
   output logic [W-1:0] mag
);

   always_comb begin
      sign = value[W-1];
      mag  = value[W-1] ? (~value + W'(1)) : value;
   end

endmodule : calc_mag_split

`default_nettype wire

// File: rtl/calc_muldiv_sequencer.sv
// ============================================================================
// Module      : calc_muldiv_sequencer
// Description : Multi-cycle signed multiply / divide sequencer. Operands are
//               reduced to magnitudes, processed by a W-step shift-add
//               multiplier or restoring divider, and the sign is re-applied
//               at the end together with overflow / divide-by-zero flags.
// Ports       : Clock     - system clock, rising edge
//               Clear     - asynchronous active-high reset
//               Start     - request, honoured only in IDLE
//               Op        - 0 multiply, 1 divide (latched with Start)
//               A, B      - signed operands (latched with Start)
//               Busy      - high whenever State != IDLE
//               Done      - one-cycle completion pulse
//               Result    - signed result, held between operations
//               Overflow  - result not representable in W bits
//               DivByZero - divide with B == 0
//               State     - current FSM state code
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_muldiv_sequencer
   import calc_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = 4
) (
   input  logic         Clock,
   input  logic         Clear,
   input  logic         Start,
   input  logic         Op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         Busy,
   output logic         Done,
   output logic [W-1:0] Result,
   output logic         Overflow,
   output logic         DivByZero,
   output logic [2:0]   State
);

   // Largest magnitudes representable as positive / negative W-bit results.
   localparam logic [2*W-1:0] POS_MAX = (2*W)'((1 << (W-1)) - 1);
   localparam logic [2*W-1:0] NEG_MAX = (2*W)'(1 << (W-1));

   // ------------------------------------------------------------------------
   // Operand magnitude extraction
   // ------------------------------------------------------------------------
   logic         a_sign;
   logic         b_sign;
   logic [W-1:0] a_mag;
   logic [W-1:0] b_mag;

   calc_mag_split #(.W(W)) u_split_a (
      .value (A),
      .sign  (a_sign),
      .mag   (a_mag)
   );

   calc_mag_split #(.W(W)) u_split_b (
      .value (B),
      .sign  (b_sign),
      .mag   (b_mag)
   );

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_e             state_q,  state_d;
   logic               op_q,     op_d;
   logic               sgn_q,    sgn_d;
   logic               dz_q,     dz_d;
   logic [W-1:0]       a_mag_q,  a_mag_d;
   logic [W-1:0]       b_mag_q,  b_mag_d;
   // acc holds the running upper product half (multiply) or the partial
   // remainder (divide); mq holds the multiplier / quotient bits.
   logic [W:0]         acc_q,    acc_d;
   logic [W-1:0]       mq_q,     mq_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [W-1:0]       result_q, result_d;
   logic               ovf_q,    ovf_d;
   logic               dbz_q,    dbz_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;

   // ------------------------------------------------------------------------
   // Datapath step logic
   // ------------------------------------------------------------------------
   logic [W:0]         mul_sum;
   logic [W:0]         div_shift;
   logic [W+1:0]       div_diff;
   logic               div_ge;
   logic [2*W-1:0]     mag;
   logic               mag_ovf;

   always_comb begin
      // Shift-add: conditionally add the multiplicand, then shift right.
      mul_sum   = acc_q + {1'b0, a_mag_q};

      // Restoring divide: bring the next dividend bit into the remainder and
      // trial-subtract the divisor; one extra bit catches the borrow.
      div_shift = {acc_q[W-1:0], mq_q[W-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
      div_ge    = ~div_diff[W+1];

      mag       = (op_q == OP_DIV) ? {{W{1'b0}}, mq_q} : {acc_q[W-1:0], mq_q};
      mag_ovf   = sgn_q ? (mag > NEG_MAX) : (mag > POS_MAX);
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sgn_d    = sgn_q;
      dz_d     = dz_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      dbz_d    = dbz_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               op_d    = Op;
               a_mag_d = a_mag;
               b_mag_d = b_mag;
               sgn_d   = a_sign ^ b_sign;
               dz_d    = 1'b0;
               state_d = LOAD;
            end
         end

         LOAD: begin
            cnt_d = CNT_W'(W - 1);
            acc_d = '0;
            // Multiply consumes the multiplier from mq; divide shifts the
            // dividend out of mq while the quotient shifts in behind it.
            mq_d  = (op_q == OP_DIV) ? a_mag_q : b_mag_q;
            if (op_q == OP_MUL) begin
               state_d = MUL;
            end else if (b_mag_q == '0) begin
               dz_d    = 1'b1;
               state_d = SIGN;
            end else begin
               state_d = DIV;
            end
         end

         MUL: begin
            {acc_d, mq_d} = {(mq_q[0] ? mul_sum : acc_q), mq_q} >> 1;
            if (cnt_q == '0) begin
               state_d = SIGN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         DIV: begin
            acc_d = div_ge ? div_diff[W:0] : div_shift;
            mq_d  = {mq_q[W-2:0], div_ge};
            if (cnt_q == '0) begin
               state_d = SIGN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         SIGN: begin
            dbz_d = dz_q;
            if (dz_q) begin
               result_d = '0;
               ovf_d    = 1'b0;
            end else begin
               ovf_d    = mag_ovf;
               // Two's-complement negation of zero stays zero, so a zero
               // magnitude never produces a negative result.
               result_d = sgn_q ? (~mag[W-1:0] + W'(1)) : mag[W-1:0];
            end
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the State register.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q  <= IDLE;
         op_q     <= 1'b0;
         sgn_q    <= 1'b0;
         dz_q     <= 1'b0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sgn_q    <= sgn_d;
         dz_q     <= dz_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         dbz_q    <= dbz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Result    = result_q;
   assign Overflow  = ovf_q;
   assign DivByZero = dbz_q;
   assign State     = state_q;

endmodule : calc_muldiv_sequencer

`default_nettype wire
